// File: rtl/mouse_cursor_if.sv
// Handshake bundle between the mouse packet source / cursor consumer and mouse_cursor_ctrl.
// The slave modport is the controller's view; the master modport is the surrounding logic.
interface mouse_cursor_if;
  logic        pkt_valid;
  logic [8:0]  pkt_dx;
  logic [8:0]  pkt_dy;
  logic [2:0]  pkt_buttons;
  logic        upd_ready;
  logic        upd_valid;
  logic [10:0] cursor_x;
  logic [10:0] cursor_y;
  logic [2:0]  buttons;
  logic [2:0]  click;
  logic [7:0]  drop_cnt;
  logic [4:0]  fifo_level;

  modport master (
    output pkt_valid, pkt_dx, pkt_dy, pkt_buttons, upd_ready,
    input  upd_valid, cursor_x, cursor_y, buttons, click, drop_cnt, fifo_level
  );

  modport slave (
    input  pkt_valid, pkt_dx, pkt_dy, pkt_buttons, upd_ready,
    output upd_valid, cursor_x, cursor_y, buttons, click, drop_cnt, fifo_level
  );
endinterface

// File: rtl/mouse_cursor_ctrl.sv
// Queues relative mouse packets and turns them into a clamped absolute cursor position,
// presented one update at a time over a valid/ready handshake.
module mouse_cursor_ctrl #(
  parameter int SCR_W      = 1024,
  parameter int SCR_H      = 768,
  parameter int INIT_X     = 512,
  parameter int INIT_Y     = 384,
  parameter int FIFO_DEPTH = 4,
  parameter int INVERT_Y   = 1
) (
  input  logic           clk,
  input  logic           rst,
  mouse_cursor_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0]         LVL_FULL = 5'(FIFO_DEPTH);
  localparam logic signed [12:0] X_MAX    = 13'(SCR_W - 1);
  localparam logic signed [12:0] Y_MAX    = 13'(SCR_H - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  logic [20:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [8:0]    hold_dx_q, hold_dx_d, hold_dy_q, hold_dy_d;
  logic [2:0]    hold_btn_q, hold_btn_d;
  logic [10:0]   cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
  logic [2:0]    buttons_q, buttons_d, click_q, click_d;
  logic          push, drop, pop;
  logic signed [12:0] dx_ext, dy_ext, nx, ny;
  logic [10:0]   x_clamped, y_clamped;

  // Full test uses the registered level, so a same-cycle pop never makes room for a push.
  assign push = bus.pkt_valid && (level_q != LVL_FULL);
  assign drop = bus.pkt_valid && (level_q == LVL_FULL);
  assign pop  = (state_q == ST_IDLE) && (level_q != 5'd0);

  // NOTE: the packet storage has no reset; occupancy is tracked by level_q, so stale
  // entries are never read and leaving the array unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.pkt_dx, bus.pkt_dy, bus.pkt_buttons};
  end

  always_comb begin
    dx_ext = $signed({{4{hold_dx_q[8]}}, hold_dx_q});
    dy_ext = $signed({{4{hold_dy_q[8]}}, hold_dy_q});
    nx     = $signed({2'b00, cursor_x_q}) + dx_ext;
    if (INVERT_Y != 0) ny = $signed({2'b00, cursor_y_q}) - dy_ext;
    else               ny = $signed({2'b00, cursor_y_q}) + dy_ext;

    if (nx < 13'sd0)       x_clamped = 11'd0;
    else if (nx > X_MAX)   x_clamped = X_MAX[10:0];
    else                   x_clamped = nx[10:0];

    if (ny < 13'sd0)       y_clamped = 11'd0;
    else if (ny > Y_MAX)   y_clamped = Y_MAX[10:0];
    else                   y_clamped = ny[10:0];
  end

  // NOTE: every signal assigned here gets its hold value first, so no path infers a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    state_d    = state_q;
    hold_dx_d  = hold_dx_q;
    hold_dy_d  = hold_dy_q;
    hold_btn_d = hold_btn_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    buttons_d  = buttons_q;
    click_d    = click_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + 5'd1;
    else if (!push && pop) level_d = level_q - 5'd1;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          {hold_dx_d, hold_dy_d, hold_btn_d} = mem_q[rd_ptr_q];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cursor_x_d = x_clamped;
        cursor_y_d = y_clamped;
        click_d    = hold_btn_q & ~buttons_q;
        buttons_d  = hold_btn_q;
        state_d    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.upd_ready) begin
          click_d = 3'b000;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      state_q    <= ST_IDLE;
      hold_dx_q  <= '0;
      hold_dy_q  <= '0;
      hold_btn_q <= '0;
      cursor_x_q <= 11'(INIT_X);
      cursor_y_q <= 11'(INIT_Y);
      buttons_q  <= '0;
      click_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      hold_dx_q  <= hold_dx_d;
      hold_dy_q  <= hold_dy_d;
      hold_btn_q <= hold_btn_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      buttons_q  <= buttons_d;
      click_q    <= click_d;
    end
  end

  assign bus.upd_valid  = (state_q == ST_PRESENT);
  assign bus.cursor_x   = cursor_x_q;
  assign bus.cursor_y   = cursor_y_q;
  assign bus.buttons    = buttons_q;
  assign bus.click      = click_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.fifo_level = level_q;

endmodule

// File: tb/tb_mouse_cursor_ctrl.sv
// Directed bench for mouse_cursor_ctrl: latency, clamping, click edges, back-pressure,
// drop-counter saturation and reset during a pending handshake.
module tb_mouse_cursor_ctrl;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mouse_cursor_if bus();

  mouse_cursor_ctrl #(
    .SCR_W(1024), .SCR_H(768), .INIT_X(512), .INIT_Y(384),
    .FIFO_DEPTH(4), .INVERT_Y(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic send_pkt(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] btn);
    @(negedge clk);
    bus.pkt_valid   = 1'b1;
    bus.pkt_dx      = dx;
    bus.pkt_dy      = dy;
    bus.pkt_buttons = btn;
    @(negedge clk);
    bus.pkt_valid   = 1'b0;
  endtask

  // Steps at least one negedge, then waits (bounded) for upd_valid.
  task automatic wait_valid(input string name, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.upd_valid !== 1'b1 && waited < 20);
    checks++;
    if (bus.upd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: upd_valid=%b after %0d cycles, required 1", name, bus.upd_valid, waited);
    end
  endtask

  // One packet with upd_ready held high: latency, values, single-cycle valid.
  task automatic run_update(input string name, input logic [8:0] dx, input logic [8:0] dy,
                            input logic [2:0] btn, input logic [10:0] ex, input logic [10:0] ey,
                            input logic [2:0] eb, input logic [2:0] ec);
    int waited;
    bus.upd_ready = 1'b1;
    send_pkt(dx, dy, btn);
    wait_valid(name, waited);
    checks++;
    if (waited !== 2) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles after push, required 2", name, waited);
    end
    checks++;
    if ({bus.cursor_x, bus.cursor_y} !== {ex, ey}) begin
      errors++;
      $display("FAIL %s cursor: got (%0d,%0d), required (%0d,%0d)", name, bus.cursor_x, bus.cursor_y, ex, ey);
    end
    checks++;
    if ({bus.buttons, bus.click} !== {eb, ec}) begin
      errors++;
      $display("FAIL %s buttons/click: got %b/%b, required %b/%b", name, bus.buttons, bus.click, eb, ec);
    end
    @(negedge clk);
    checks++;
    if ({bus.upd_valid, bus.click} !== 4'b0000) begin
      errors++;
      $display("FAIL %s after handshake: upd_valid=%b click=%b, required 0/000", name, bus.upd_valid, bus.click);
    end
  endtask

  task automatic test_reset;
    rst             = 1'b1;
    bus.pkt_valid   = 1'b0;
    bus.pkt_dx      = '0;
    bus.pkt_dy      = '0;
    bus.pkt_buttons = '0;
    bus.upd_ready   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.upd_valid, bus.cursor_x, bus.cursor_y, bus.buttons, bus.click, bus.drop_cnt, bus.fifo_level}
        !== {1'b0, 11'd512, 11'd384, 3'b000, 3'b000, 8'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_state: valid=%b x=%0d y=%0d btn=%b click=%b drop=%0d lvl=%0d, required 0 512 384 000 000 0 0",
               bus.upd_valid, bus.cursor_x, bus.cursor_y, bus.buttons, bus.click, bus.drop_cnt, bus.fifo_level);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: upd_valid=%b, required 0", bus.upd_valid);
    end
  endtask

  task automatic test_single_update;
    run_update("single", 9'd10, 9'd5, 3'b001, 11'd522, 11'd379, 3'b001, 3'b001);
  endtask

  task automatic test_x_saturation;
    int dxs [7] = '{255, 243, 255, -256, -256, -256, -256};
    int exs [7] = '{777, 1020, 1023, 767, 511, 255, 0};
    for (int i = 0; i < 7; i++)
      run_update($sformatf("x_sat[%0d]", i), 9'(dxs[i]), 9'd0, 3'b000, 11'(exs[i]), 11'd379, 3'b000, 3'b000);
  endtask

  task automatic test_y_saturation;
    int dys [7] = '{-256, -128, -255, 255, 255, 255, 255};
    int eys [7] = '{635, 763, 767, 512, 257, 2, 0};
    for (int i = 0; i < 7; i++)
      run_update($sformatf("y_sat[%0d]", i), 9'd0, 9'(dys[i]), 3'b000, 11'd0, 11'(eys[i]), 3'b000, 3'b000);
  endtask

  task automatic test_clicks;
    run_update("click_press",  9'd0, 9'd0, 3'b001, 11'd0, 11'd0, 3'b001, 3'b001);
    run_update("click_hold",   9'd0, 9'd0, 3'b001, 11'd0, 11'd0, 3'b001, 3'b000);
    run_update("click_right",  9'd0, 9'd0, 3'b011, 11'd0, 11'd0, 3'b011, 3'b010);
  endtask

  task automatic test_stall_backpressure;
    int exp_x [5] = '{1, 3, 6, 10, 15};
    int waited;
    bus.upd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_pkt(9'(i + 1), 9'd0, 3'b000);
      repeat (3) @(negedge clk);
      if (i == 2) begin
        checks++;
        if ({bus.upd_valid, bus.cursor_x, bus.fifo_level} !== {1'b1, 11'd1, 5'd2}) begin
          errors++;
          $display("FAIL stall_mid: valid=%b x=%0d lvl=%0d, required 1 1 2", bus.upd_valid, bus.cursor_x, bus.fifo_level);
        end
      end
    end
    checks++;
    if ({bus.upd_valid, bus.cursor_x, bus.cursor_y, bus.click} !== {1'b1, 11'd1, 11'd0, 3'b000}) begin
      errors++;
      $display("FAIL stall_hold: valid=%b x=%0d y=%0d click=%b, required 1 1 0 000",
               bus.upd_valid, bus.cursor_x, bus.cursor_y, bus.click);
    end
    checks++;
    if ({bus.fifo_level, bus.drop_cnt} !== {5'd4, 8'd1}) begin
      errors++;
      $display("FAIL stall_full: lvl=%0d drop=%0d, required 4 1", bus.fifo_level, bus.drop_cnt);
    end
    bus.upd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_valid($sformatf("drain[%0d]", i), waited);
      checks++;
      if (bus.cursor_x !== 11'(exp_x[i])) begin
        errors++;
        $display("FAIL drain[%0d] order: x=%0d, required %0d", i, bus.cursor_x, exp_x[i]);
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.upd_valid, bus.fifo_level, bus.cursor_x} !== {1'b0, 5'd0, 11'd15}) begin
      errors++;
      $display("FAIL drain_done: valid=%b lvl=%0d x=%0d, required 0 0 15", bus.upd_valid, bus.fifo_level, bus.cursor_x);
    end
  endtask

  task automatic test_drop_saturation;
    int waited;
    bus.upd_ready = 1'b0;
    send_pkt(9'd0, 9'd0, 3'b000);
    wait_valid("sat_first", waited);
    for (int i = 0; i < 4; i++) send_pkt(9'd0, 9'd0, 3'b000);
    checks++;
    if ({bus.fifo_level, bus.drop_cnt} !== {5'd4, 8'd1}) begin
      errors++;
      $display("FAIL sat_fill: lvl=%0d drop=%0d, required 4 1", bus.fifo_level, bus.drop_cnt);
    end
    bus.pkt_valid = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (bus.drop_cnt !== 8'd101) begin
      errors++;
      $display("FAIL sat_count: drop=%0d, required 101", bus.drop_cnt);
    end
    repeat (200) @(negedge clk);
    bus.pkt_valid = 1'b0;
    checks++;
    if (bus.drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_limit: drop=%0d, required 255", bus.drop_cnt);
    end
    @(negedge clk);
    checks++;
    if ({bus.fifo_level, bus.upd_valid} !== {5'd4, 1'b1}) begin
      errors++;
      $display("FAIL sat_after: lvl=%0d valid=%b, required 4 1", bus.fifo_level, bus.upd_valid);
    end
  endtask

  task automatic test_reset_mid_handshake;
    int waited;
    bit stale;
    bus.upd_ready = 1'b1;
    @(negedge clk);
    bus.upd_ready = 1'b0;
    wait_valid("rst_setup", waited);
    checks++;
    if ({bus.upd_valid, bus.fifo_level} !== {1'b1, 5'd3}) begin
      errors++;
      $display("FAIL rst_setup state: valid=%b lvl=%0d, required 1 3", bus.upd_valid, bus.fifo_level);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.upd_valid, bus.cursor_x, bus.cursor_y, bus.fifo_level, bus.drop_cnt}
        !== {1'b0, 11'd512, 11'd384, 5'd0, 8'd0}) begin
      errors++;
      $display("FAIL rst_async: valid=%b x=%0d y=%0d lvl=%0d drop=%0d, required 0 512 384 0 0",
               bus.upd_valid, bus.cursor_x, bus.cursor_y, bus.fifo_level, bus.drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.upd_valid !== 1'b0 || bus.fifo_level !== 5'd0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL rst_stale: an update or queued packet survived reset (valid=%b lvl=%0d), required none",
               bus.upd_valid, bus.fifo_level);
    end
    run_update("post_rst", 9'd1, 9'd0, 3'b000, 11'd513, 11'd384, 3'b000, 3'b000);
  endtask

  initial begin
    test_reset;
    test_single_update;
    test_x_saturation;
    test_y_saturation;
    test_clicks;
    test_stall_backpressure;
    test_drop_saturation;
    test_reset_mid_handshake;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_ctrl.md
Name: mouse_cursor_ctrl

Overview:
Sequences decoded mouse packets (dx, dy, buttons, one-cycle valid from the UART mouse receiver) into an absolute, screen-clamped cursor position for downstream display logic. A small packet FIFO absorbs bursts while the consumer stalls. A 3-state FSM pops one packet at a time, applies it with saturation, and presents the result over a valid/ready handshake. Press-edge click pulses and a saturating drop counter are also produced.

Parameters:
SCR_W, 1024, screen width in pixels; cursor_x range 0..SCR_W-1; legal 2..2048
SCR_H, 768, screen height in pixels; cursor_y range 0..SCR_H-1; legal 2..2048
INIT_X, 512, cursor_x after reset
INIT_Y, 384, cursor_y after reset
FIFO_DEPTH, 4, packet FIFO entries; power of 2, legal 2..16
INVERT_Y, 1, 1: cursor_y -= dy (PS/2 +dy is up); 0: cursor_y += dy

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pkt_valid  in  1  one-cycle pulse, packet present on pkt_dx/pkt_dy/pkt_buttons
pkt_dx  in  9  signed two's-complement X delta
pkt_dy  in  9  signed two's-complement Y delta
pkt_buttons  in  3  {middle, right, left}, 1 = pressed
upd_ready  in  1  consumer accepts current update
upd_valid  out  1  cursor_x/cursor_y/buttons/click hold a new update
cursor_x  out  11  absolute X, unsigned
cursor_y  out  11  absolute Y, unsigned
buttons  out  3  button state of the last applied packet
click  out  3  press edges of the last applied packet (new & ~previous)
drop_cnt  out  8  packets dropped because the FIFO was full; saturates at 255
fifo_level  out  5  current FIFO occupancy

Behaviour:
- Reset (async, immediate): cursor_x=INIT_X, cursor_y=INIT_Y, buttons=0, click=0, upd_valid=0, drop_cnt=0, FIFO emptied (fifo_level=0), FSM=IDLE. Reset mid-handshake discards the pending update and all queued packets.
- FIFO push: on pkt_valid, the 21-bit entry {dx, dy, buttons} is written if fifo_level < FIFO_DEPTH.
- If fifo_level == FIFO_DEPTH, the packet is dropped and drop_cnt is incremented, saturating at 255. The full check uses registered fifo_level, so a packet is still dropped when a pop occurs in the same cycle.
- Push and pop in the same cycle: level unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM IDLE: upd_valid=0. If fifo_level != 0, pop the head into holding registers and go to LOAD.
- FSM LOAD, one cycle:
  - Compute nx = cursor_x + sext(dx) in 13-bit signed arithmetic. Clamp: nx<0 gives 0; nx>SCR_W-1 gives SCR_W-1.
  - Compute ny = cursor_y - sext(dy) when INVERT_Y=1, or cursor_y + sext(dy) when INVERT_Y=0. Clamp to 0..SCR_H-1.
  - At the clock edge: cursor_x=nx, cursor_y=ny, click = hold_btn & ~buttons (uses the old buttons), buttons = hold_btn. Go to PRESENT.
- FSM PRESENT: upd_valid=1. Outputs are stable until the handshake completes.
  - upd_ready=1 completes the transfer that cycle. Next state is IDLE; upd_valid=0 the following cycle.
  - upd_ready is ignored outside PRESENT.
- Click pulses: click is valid only while upd_valid=1 and is cleared to 0 on the handshake cycle.
- Latency: pkt_valid sampled at edge E0 into an empty FIFO. The FSM pops at E1, outputs update at E2, and upd_valid=1 from E2. With upd_ready held at 1, throughput is one packet per 3 cycles.
- Zero deltas still produce an update, because button changes must propagate.
- fifo_level counts only queued packets; the packet being applied or presented is not included.

Test Plan:
- Reset, one packet dx=+10, dy=+5, btn=001, upd_ready=1 -> upd_valid at E2 with cursor_x=522, cursor_y=379, buttons=001, click=001; single-cycle valid.
- cursor_x=1020, packet dx=+255 -> cursor_x=1023. Then dx=-256 three times, then -256 again -> 767, 511, 255, 0 (saturates at 0). Same pattern for Y in the 0..767 range.
- Hold btn=001 across two packets -> click=001 on the first update, 000 on the second. Then btn=011 -> click=010, buttons=011.
- upd_ready=0, six pkt_valid pulses 4 cycles apart -> first packet held in PRESENT, next 4 queued (fifo_level=4), 6th dropped (drop_cnt=1). Release upd_ready -> 5 updates delivered in FIFO order, outputs stable while stalled.
- 300 pushes while stalled with a full FIFO -> drop_cnt saturates at 255.
- Assert rst while in PRESENT with fifo_level=3 -> upd_valid=0 immediately, cursor=(512,384), fifo_level=0. No stale update after rst falls.
